// File: rtl/bsg_manycore_tile_stall_counter_if.sv
// Drain stream from the tile stall counter: valid/yumi handshake plus word index.
// master = counter (producer), slave = I/O complex or trace sink (consumer).
interface bsg_manycore_tile_stall_counter_if #(
    parameter int unsigned counter_width_p = 32,
    parameter int unsigned idx_width_p     = 3
);
    logic                       v_o;
    logic [counter_width_p-1:0] data_o;
    logic [idx_width_p-1:0]     idx_o;
    logic                       yumi_i;

    modport master (output v_o, output data_o, output idx_o, input yumi_i);
    modport slave  (input v_o, input data_o, input idx_o, output yumi_i);
endinterface

// File: rtl/bsg_manycore_tile_stall_counter.sv
// Per-tile stall profiler: saturating per-event and cycle counters, drained after finish.
// Define BSG_MANYCORE_STALL_OVERLAP_EN to add a word counting cycles with >=2 events high.
module bsg_manycore_tile_stall_counter #(
    parameter int unsigned num_events_p    = 7,
    parameter int unsigned counter_width_p = 32
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    input  logic                                     start_i,
    input  logic                                     finish_i,
    input  logic [num_events_p-1:0]                  event_i,
    bsg_manycore_tile_stall_counter_if.master        drain_if,
    output logic                                     busy_o,
    output logic                                     done_o
);

`ifdef BSG_MANYCORE_STALL_OVERLAP_EN
    localparam int unsigned num_words_lp = num_events_p + 2;
`else
    localparam int unsigned num_words_lp = num_events_p + 1;
`endif
    localparam int unsigned idx_width_lp = (num_words_lp > 1) ? $clog2(num_words_lp) : 1;
    localparam logic [idx_width_lp-1:0] last_idx_lp = idx_width_lp'(num_words_lp - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                     r_state, w_state_d;
    logic [idx_width_lp-1:0]    r_idx, w_idx_d;
    logic [counter_width_p-1:0] r_cnt   [num_words_lp];
    logic [counter_width_p-1:0] w_cnt_d [num_words_lp];
    logic [num_words_lp-1:0]    w_inc;
    logic                       w_clear, w_count;
    logic                       r_v, r_busy, r_done;
    logic                       w_v_d, w_busy_d, w_done_d;
    logic [counter_width_p-1:0] r_data, w_data_d;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // finish_i has priority over start_i in RUN; neither cycle is counted.
    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_clear   = 1'b0;
        w_count   = 1'b0;
        case (r_state)
            StIdle, StDone: begin
                if (start_i) begin
                    w_clear   = 1'b1;
                    w_state_d = StRun;
                end
            end
            StRun: begin
                if (finish_i) begin
                    w_state_d = StDrain;
                end else if (start_i) begin
                    w_clear = 1'b1;
                end else begin
                    w_count = 1'b1;
                end
            end
            StDrain: begin
                if (drain_if.yumi_i) begin
                    if (r_idx == last_idx_lp) begin
                        w_idx_d   = '0;
                        w_state_d = StDone;
                    end else begin
                        w_idx_d = r_idx + idx_width_lp'(1);
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_inc                 = '0;
        w_inc[0]              = 1'b1;
        w_inc[num_events_p:1] = event_i;
`ifdef BSG_MANYCORE_STALL_OVERLAP_EN
        // x & (x-1) clears the lowest set bit; nonzero means two or more bits were set.
        w_inc[num_words_lp-1] = |(event_i & (event_i - num_events_p'(1)));
`endif
        for (int unsigned k = 0; k < num_words_lp; k++) begin
            w_cnt_d[k] = r_cnt[k];
            if (w_clear) begin
                w_cnt_d[k] = '0;
            end else if (w_count && w_inc[k] && (r_cnt[k] != '1)) begin
                w_cnt_d[k] = r_cnt[k] + counter_width_p'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int unsigned k = 0; k < num_words_lp; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < num_words_lp; k++) begin
                r_cnt[k] <= w_cnt_d[k];
            end
        end
    end

    // Outputs are decoded from next state so they land in flops alongside the state.
    always_comb begin
        w_v_d    = (w_state_d == StDrain);
        w_busy_d = (w_state_d == StRun);
        w_done_d = (w_state_d == StDone);
        w_data_d = '0;
        if (w_v_d) begin
            for (int unsigned k = 0; k < num_words_lp; k++) begin
                if (w_idx_d == idx_width_lp'(k)) begin
                    w_data_d = w_cnt_d[k];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_idx  <= '0;
            r_v    <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_data <= '0;
        end else begin
            r_idx  <= w_idx_d;
            r_v    <= w_v_d;
            r_busy <= w_busy_d;
            r_done <= w_done_d;
            r_data <= w_data_d;
        end
    end

    assign drain_if.v_o    = r_v;
    assign drain_if.data_o = r_data;
    assign drain_if.idx_o  = r_idx;
    assign busy_o          = r_busy;
    assign done_o          = r_done;

endmodule

// File: tb/tb_bsg_manycore_tile_stall_counter.sv
// Directed bench for the tile stall counter: a 32-bit instance plus a 4-bit one for saturation.
module tb_bsg_manycore_tile_stall_counter;
    localparam int unsigned NE = 7;
`ifdef BSG_MANYCORE_STALL_OVERLAP_EN
    localparam int unsigned NW = NE + 2;
`else
    localparam int unsigned NW = NE + 1;
`endif
    localparam int unsigned IW = $clog2(NW);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          finish = 1'b0;
    logic          yumi = 1'b0;
    logic [NE-1:0] ev = '0;
    logic          busy, done, busy_s, done_s;
    logic [31:0]   exp_w [NW];
    int            n_checks = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    bsg_manycore_tile_stall_counter_if #(.counter_width_p(32), .idx_width_p(IW)) if32 ();
    bsg_manycore_tile_stall_counter_if #(.counter_width_p(4), .idx_width_p(IW)) if4 ();

    assign if32.yumi_i = yumi;
    assign if4.yumi_i  = yumi;

    bsg_manycore_tile_stall_counter #(.num_events_p(NE), .counter_width_p(32)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .start_i   (start),
        .finish_i  (finish),
        .event_i   (ev),
        .drain_if  (if32),
        .busy_o    (busy),
        .done_o    (done)
    );

    bsg_manycore_tile_stall_counter #(.num_events_p(NE), .counter_width_p(4)) dut_sat (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .start_i   (start),
        .finish_i  (finish),
        .event_i   (ev),
        .drain_if  (if4),
        .busy_o    (busy_s),
        .done_o    (done_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < int'(NW); i++) exp_w[i] = '0;
    endtask

    task automatic drain(input string tag, input int unsigned from);
        for (int unsigned i = from; i < NW; i++) begin
            check({tag, "_v"}, 32'(if32.v_o), 32'd1);
            check({tag, "_idx"}, 32'(if32.idx_o), i);
            check({tag, "_data"}, if32.data_o, exp_w[i]);
            yumi = 1'b1;
            tick();
        end
        yumi = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_v_end"}, 32'(if32.v_o), 32'd0);
        check({tag, "_data_end"}, if32.data_o, 32'd0);
        check({tag, "_idx_end"}, 32'(if32.idx_o), 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_v", 32'(if32.v_o), 32'd0);
        check("rst_data", if32.data_o, 32'd0);
        check("rst_idx", 32'(if32.idx_o), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset_n = 1'b1;

        // finish ignored in IDLE
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("idle_fin_busy", 32'(busy), 32'd0);
        check("idle_fin_v", 32'(if32.v_o), 32'd0);

        // 10 cycles: ev[2] always, ev[0] first 4; ev[2] also high on the uncounted finish cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        check("a_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 10; i++) begin
            ev = (i < 4) ? 7'b0000101 : 7'b0000100;
            tick();
        end
        ev = 7'b0000100;
        finish = 1'b1;
        tick();
        finish = 1'b0;
        ev = '0;
        check("a_busy_drain", 32'(busy), 32'd0);
        clear_exp();
        exp_w[0] = 32'd10;
        exp_w[1] = 32'd4;
        exp_w[3] = 32'd10;
`ifdef BSG_MANYCORE_STALL_OVERLAP_EN
        exp_w[NW-1] = 32'd4;
`endif
        drain("a", 0);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("done_fin_done", 32'(done), 32'd1);
        check("done_fin_v", 32'(if32.v_o), 32'd0);

        // yumi 1,0,0,1 with events and start high during DRAIN
        start = 1'b1;
        tick();
        start = 1'b0;
        ev = 7'b0000001; tick();
        ev = 7'b0000001; tick();
        ev = 7'b0000011; tick();
        ev = 7'b0000010; tick();
        ev = '0;
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("b_idx0", 32'(if32.idx_o), 32'd0);
        check("b_data0", if32.data_o, 32'd4);
        ev = '1;
        start = 1'b1;
        yumi = 1'b1;
        tick();
        check("b_idx1", 32'(if32.idx_o), 32'd1);
        check("b_data1", if32.data_o, 32'd3);
        yumi = 1'b0;
        tick();
        check("b_hold1_idx", 32'(if32.idx_o), 32'd1);
        check("b_hold1_data", if32.data_o, 32'd3);
        check("b_hold1_busy", 32'(busy), 32'd0);
        tick();
        check("b_hold2_idx", 32'(if32.idx_o), 32'd1);
        check("b_hold2_data", if32.data_o, 32'd3);
        yumi = 1'b1;
        tick();
        yumi = 1'b0;
        start = 1'b0;
        ev = '0;
        clear_exp();
        exp_w[0] = 32'd4;
        exp_w[1] = 32'd3;
        exp_w[2] = 32'd2;
`ifdef BSG_MANYCORE_STALL_OVERLAP_EN
        exp_w[NW-1] = 32'd1;
`endif
        drain("b", 2);

        // start and finish together after 5 RUN cycles: finish wins
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        start = 1'b1;
        finish = 1'b1;
        tick();
        start = 1'b0;
        finish = 1'b0;
        check("c_v", 32'(if32.v_o), 32'd1);
        clear_exp();
        exp_w[0] = 32'd5;
        drain("c", 0);

        // restart on cycle 3 of a window; start cycle itself is not counted
        start = 1'b1;
        tick();
        start = 1'b0;
        ev = 7'b0000001;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        finish = 1'b1;
        tick();
        finish = 1'b0;
        ev = '0;
        clear_exp();
        exp_w[0] = 32'd4;
        exp_w[1] = 32'd4;
        drain("r", 0);

        // saturation on the 4-bit instance: 20 cycles of ev[1]
        start = 1'b1;
        tick();
        start = 1'b0;
        ev = 7'b0000010;
        repeat (20) tick();
        ev = '0;
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("s_w0_sat", 32'(if4.data_o), 32'd15);
        check("s_w0_wide", if32.data_o, 32'd20);
        yumi = 1'b1;
        tick();
        check("s_w1_sat", 32'(if4.data_o), 32'd0);
        tick();
        check("s_w2_sat", 32'(if4.data_o), 32'd15);
        check("s_w2_wide", if32.data_o, 32'd20);
        repeat (NW - 2) tick();
        yumi = 1'b0;
        check("s_done", 32'(done_s), 32'd1);

        // overlap pattern: 3 cycles of ev=3, 3 of ev=1
        start = 1'b1;
        tick();
        start = 1'b0;
        ev = 7'b0000011;
        repeat (3) tick();
        ev = 7'b0000001;
        repeat (3) tick();
        ev = '0;
        finish = 1'b1;
        tick();
        finish = 1'b0;
        clear_exp();
        exp_w[0] = 32'd6;
        exp_w[1] = 32'd6;
        exp_w[2] = 32'd3;
`ifdef BSG_MANYCORE_STALL_OVERLAP_EN
        exp_w[NW-1] = 32'd3;
`endif
        drain("o", 0);

        // reset mid-drain at idx 3
        start = 1'b1;
        tick();
        start = 1'b0;
        ev = '1;
        repeat (2) tick();
        ev = '0;
        finish = 1'b1;
        tick();
        finish = 1'b0;
        yumi = 1'b1;
        repeat (3) tick();
        yumi = 1'b0;
        check("m_idx3", 32'(if32.idx_o), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        check("m_rst_v", 32'(if32.v_o), 32'd0);
        check("m_rst_idx", 32'(if32.idx_o), 32'd0);
        check("m_rst_done", 32'(done), 32'd0);
        check("m_rst_data", if32.data_o, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("m_idle_busy", 32'(busy), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        finish = 1'b1;
        tick();
        finish = 1'b0;
        clear_exp();
        drain("m", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
